// File: rtl/timer_display.sv
// Display stage for the countdown timer: sequential double-dabble BCD conversion feeding a
// 4-digit multiplexed, active-low 7-segment display (MM.SS). Optional macro: LEADING_ZERO_BLANK_EN.
module timer_display #(
    parameter int SCAN_DIV   = 1,
    parameter int BLINK_HALF = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1k,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       conv_busy
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } conv_state_t;

    conv_state_t state, state_n;

    logic [5:0]       min_shadow, sec_shadow;
    logic [13:0]      min_sr, sec_sr;
    logic [2:0]       iter_cnt;
    logic [3:0][3:0]  disp;
    logic             capture, load, shift_en, commit;

    logic [SCAN_W-1:0]  scan_cnt, scan_cnt_n;
    logic [1:0]         idx, idx_n;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
    logic               blink_off, blink_off_n;
    logic [3:0]         digit;
    logic [3:0]         an_n;
    logic [6:0]         seg_n;
    logic               dp_n;

    // Shift register layout is {tens, ones, binary}; nibbles are adjusted before each shift.
    function automatic logic [13:0] dabble_step(input logic [13:0] sr);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = sr[13:10];
        ones = sr[9:6];
        if (tens >= 4'd5) tens = tens + 4'd3;
        if (ones >= 4'd5) ones = ones + 4'd3;
        return {tens, ones, sr[5:0]} << 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] pattern;
        case (d)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'h7F;
        endcase
        return pattern;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        capture  = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (tick_1k) begin
                    capture = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (iter_cnt == 3'd5) state_n = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Minutes and seconds run through the same six iterations side by side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_shadow <= '0;
            sec_shadow <= '0;
            min_sr     <= '0;
            sec_sr     <= '0;
            iter_cnt   <= '0;
            disp       <= '0;
            conv_busy  <= 1'b0;
        end else begin
            if (capture) begin
                min_shadow <= minutes;
                sec_shadow <= seconds;
            end
            if (load) begin
                min_sr   <= {8'd0, min_shadow};
                sec_sr   <= {8'd0, sec_shadow};
                iter_cnt <= '0;
            end
            if (shift_en) begin
                min_sr   <= dabble_step(min_sr);
                sec_sr   <= dabble_step(sec_sr);
                iter_cnt <= iter_cnt + 3'd1;
            end
            if (commit) begin
                disp <= {min_sr[13:10], min_sr[9:6], sec_sr[13:10], sec_sr[9:6]};
            end
            conv_busy <= (state_n != IDLE);
        end
    end

    always_comb begin
        scan_cnt_n = scan_cnt;
        idx_n      = idx;
        if (tick_1k) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt_n = '0;
                idx_n      = idx + 2'd1;
            end else begin
                scan_cnt_n = scan_cnt + SCAN_W'(1);
            end
        end
    end

    always_comb begin
        blink_cnt_n = blink_cnt;
        blink_off_n = blink_off;
        if (!blink) begin
            blink_cnt_n = '0;
            blink_off_n = 1'b0;
        end else if (tick_1k) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n = '0;
                blink_off_n = ~blink_off;
            end else begin
                blink_cnt_n = blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Outputs are built from next-state index/phase; disp is read pre-commit on a shared edge.
    always_comb begin
        digit = disp[idx_n];
        seg_n = seg_decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_n == 2'd3) && (digit == 4'd0)) seg_n = 7'h7F;
`endif
        an_n = blink_off_n ? 4'hF : ~(4'b0001 << idx_n);
        dp_n = (idx_n != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
            an        <= 4'hF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            scan_cnt  <= scan_cnt_n;
            idx       <= idx_n;
            blink_cnt <= blink_cnt_n;
            blink_off <= blink_off_n;
            an        <= an_n;
            seg       <= seg_n;
            dp        <= dp_n;
        end
    end

endmodule

// File: tb/tb_timer_display.sv
// Scoreboard bench for timer_display: each conversion-starting tick pushes the expected digit view,
// a monitor pops it when conv_busy falls and compares the scanned an/seg/dp.
module tb_timer_display;

    localparam int SCAN_DIV   = 2;
    localparam int BLINK_HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1k;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv_busy;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } view_t;

    view_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    scan_ticks = 0;
    int    blink_ticks = 0;
    bit    blink_model = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    timer_display #(.SCAN_DIV(SCAN_DIV), .BLINK_HALF(BLINK_HALF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1k   (tick_1k),
        .minutes   (minutes),
        .seconds   (seconds),
        .blink     (blink),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .conv_busy (conv_busy)
    );

    always #5 clk = ~clk;

    function automatic bit model_off();
        return blink_model && (((blink_ticks / BLINK_HALF) % 2) == 1);
    endfunction

    // What the display should show for the given values after the ticks counted so far.
    function automatic view_t model_view(input int m, input int s);
        view_t v;
        int    digits[4];
        int    pos;
        digits[0] = s % 10;
        digits[1] = s / 10;
        digits[2] = m % 10;
        digits[3] = m / 10;
        pos = (scan_ticks / SCAN_DIV) % 4;
        v.seg = seg_tab[digits[pos]];
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 3 && digits[3] == 0) v.seg = 7'h7F;
`endif
        v.dp = (pos != 2);
        v.an = model_off() ? 4'hF : ~(4'b0001 << pos);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic pulseTick();
        @(negedge clk) tick_1k = 1'b1;
        @(negedge clk) tick_1k = 1'b0;
        scan_ticks++;
        if (blink_model) blink_ticks++;
    endtask

    task automatic applyStimulus(input int m, input int s, input bit busy_tick, input bit change_mid);
        @(negedge clk);
        minutes = 6'(m);
        seconds = 6'(s);
        pulseTick();
        if (change_mid) seconds = 6'((s + 17) % 60);
        if (busy_tick) pulseTick();
        exp_q.push_back(model_view(m, s));
        repeat (14) @(negedge clk);
    endtask

    task automatic resetModel();
        scan_ticks  = 0;
        blink_ticks = 0;
    endtask

    // Monitor: conversion length and the first scanned view after each commit.
    initial begin : monitor
        int  busy_len;
        bit  prev_busy;
        view_t e;
        busy_len  = 0;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                busy_len  = 0;
                prev_busy = 0;
            end else begin
                if (conv_busy) begin
                    busy_len++;
                end else if (prev_busy) begin
                    checkOutput("busy_len", busy_len, 8);
                    busy_len = 0;
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_conv", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("sb_an", an, e.an);
                        checkOutput("sb_seg", seg, e.seg);
                        checkOutput("sb_dp", dp, e.dp);
                    end
                end
                prev_busy = conv_busy;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        view_t v;
        rst_n   = 1'b0;
        tick_1k = 1'b0;
        minutes = '0;
        seconds = '0;
        blink   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_an", an, 4'hF);
        checkOutput("rst_seg", seg, 7'h7F);
        checkOutput("rst_dp", dp, 1'b1);
        checkOutput("rst_busy", conv_busy, 1'b0);

        rst_n = 1'b1;
        resetModel();
        @(negedge clk);
        v = model_view(0, 0);
        checkOutput("post_rst_an", an, v.an);
        checkOutput("post_rst_seg", seg, v.seg);

        for (int i = 0; i < 8; i++) applyStimulus(0, 5, 1'b0, 1'b0);
        applyStimulus(12, 34, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(12, 34, 1'b0, 1'b0);
        applyStimulus(12, 34, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(12, 51, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            applyStimulus(int'($urandom_range(63)), int'($urandom_range(63)), 1'($urandom_range(1)), 1'b0);

        @(negedge clk);
        blink = 1'b1;
        blink_model = 1;
        for (int i = 0; i < 12; i++)
            applyStimulus(int'($urandom_range(63)), int'($urandom_range(63)), 1'b0, 1'b0);
        for (int k = 0; k < 8 && !model_off(); k++)
            applyStimulus(int'($urandom_range(63)), int'($urandom_range(63)), 1'b0, 1'b0);
        v = model_view(0, 0);
        checkOutput("blink_off_an", an, v.an);
        blink = 1'b0;
        blink_model = 0;
        blink_ticks = 0;
        @(negedge clk);
        v = model_view(0, 0);
        checkOutput("blink_release_an", an, v.an);

        @(negedge clk);
        minutes = 6'd9;
        seconds = 6'd9;
        pulseTick();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", conv_busy, 1'b0);
        checkOutput("abort_an", an, 4'hF);
        checkOutput("abort_seg", seg, 7'h7F);
        checkOutput("abort_dp", dp, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        @(negedge clk);
        v = model_view(0, 0);
        checkOutput("abort_release_seg", seg, v.seg);
        checkOutput("abort_release_an", an, v.an);
        for (int i = 0; i < 8; i++) applyStimulus(7, 42, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
